lcd_stream_arbiter: RTL and testbench

//  Packet-locking round-robin arbiter sharing one LCD word FIFO write port among NUM_REQ producers
//  (e.g. init sequencer, text renderer, host bridge). Grants one requester at a time, holds the grant
//  for a whole packet (until last or MAX_BURST beats), then re-arbitrates. Output side connects

---
 rtl/lcd_stream_arbiter_pkg.sv | 12 +
 rtl/lcd_stream_arbiter_rr_picker.sv | 30 +++
 rtl/lcd_stream_arbiter.sv | 98 +++++++++
 tb/tb_lcd_stream_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_stream_arbiter_pkg.sv
// Shared types for the LCD write-port arbiter.
// Holds the FSM encoding and the default LCD word width.
package lcd_stream_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int LCD_WORD_WIDTH = 8;

endpackage

// File: rtl/lcd_stream_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational.
module lcd_stream_arbiter_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               any,
  output logic [PW-1:0]      idx
);

  int   j;
  logic found;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        idx   = PW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_stream_arbiter.sv
// Packet-locking round-robin arbiter in front of the LCD word FIFO.
// Grant is held for a whole packet or MAX_BURST beats, then re-arbitrated.
module lcd_stream_arbiter
  import lcd_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WORD_WIDTH = LCD_WORD_WIDTH,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [$clog2(NUM_REQ)-1:0]    out_src
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e    state;
  logic [SW-1:0] grant;
  logic [SW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;

  logic          pick_any;
  logic [SW-1:0] pick_idx;
  logic          locked;
  logic          burst_end;
  logic          beat;

  logic [WORD_WIDTH-1:0] words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = req_data[i*WORD_WIDTH +: WORD_WIDTH];
  end

  lcd_stream_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (SW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign locked    = (state == ST_LOCKED);
  assign burst_end = (beat_cnt == CW'(MAX_BURST - 1));
  assign out_valid = locked & req_valid[grant];
  assign out_data  = locked ? words[grant] : '0;
  assign out_last  = locked & (req_last[grant] | burst_end);
  assign out_src   = grant;
  assign beat      = out_valid & out_ready;

  always_comb begin
    req_ready = '0;
    if (locked) req_ready[grant] = out_ready;
  end

  // A beat carrying out_last ends the grant; the next cycle is always IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant    <= pick_idx;
            beat_cnt <= '0;
            state    <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (beat) begin
            if (out_last) begin
              state    <= ST_IDLE;
              beat_cnt <= '0;
              rr_ptr   <= (grant == SW'(NUM_REQ - 1)) ?
                          '0 : grant + SW'(1);
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_stream_arbiter.sv
// Bench for lcd_stream_arbiter: per-cycle reference model plus
// directed packet scenarios with literal expected beat logs.
module tb_lcd_stream_arbiter;

  localparam int NR = 2;
  localparam int WW = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*WW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic              out_valid;
  logic              out_ready;
  logic [WW-1:0]     out_data;
  logic              out_last;
  logic [0:0]        out_src;

  always #5 clk = ~clk;

  lcd_stream_arbiter #(
    .NUM_REQ    (NR),
    .WORD_WIDTH (WW),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } word_t;

  typedef struct {
    int src;
    int data;
    int last;
    int cyc;
  } beat_t;

  word_t q0[$];
  word_t q1[$];
  beat_t log_q[$];

  logic       ready_drv = 1'b1;
  bit         fifo_mode = 1'b0;
  int         fifo_n    = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] popped[$];
  bit         pop_req   = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  assign out_ready = fifo_mode ? (fifo_n < 4) : ready_drv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Requester producers and the FIFO sink.
  bit         hs0, hs1, ob;
  logic [7:0] od;
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      hs0 = req_valid[0] & req_ready[0];
      hs1 = req_valid[1] & req_ready[1];
      ob  = out_valid & out_ready;
      od  = out_data;
      @(posedge clk);
      #3;
      if (!rst) begin
        fifo_q.delete();
      end else begin
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        if (pop_req && fifo_q.size() > 0)
          popped.push_back(fifo_q.pop_front());
        if (ob && fifo_mode) fifo_q.push_back(od);
      end
      pop_req = 1'b0;
      fifo_n  = fifo_q.size();
      req_valid[0]   = q0.size() > 0;
      req_valid[1]   = q1.size() > 0;
      req_data[7:0]  = q0.size() > 0 ? q0[0].d : 8'h00;
      req_data[15:8] = q1.size() > 0 ? q1[0].d : 8'h00;
      req_last[0]    = q0.size() > 0 ? q0[0].l : 1'b0;
      req_last[1]    = q1.size() > 0 ? q1[0].l : 1'b0;
    end
  end

  // Reference model: one owner at a time, round-robin from m_ptr,
  // release after a last or the MB-th beat, one idle cycle between owners.
  bit          m_lock = 1'b0;
  int          m_own  = 0;
  int          m_ptr  = 0;
  int          m_cnt  = 0;
  int          ev, el, ed, er, jj;
  bit          fnd;
  logic [31:0] e_vec, a_vec;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      m_lock = 1'b0;
      m_own  = 0;
      m_ptr  = 0;
      m_cnt  = 0;
    end
    ev = (m_lock && req_valid[m_own]) ? 1 : 0;
    er = m_lock ? (int'(out_ready) << m_own) : 0;
    ed = m_lock ? int'(req_data[m_own*WW +: WW]) : 0;
    el = (m_lock && (req_last[m_own] || m_cnt == MB - 1)) ? 1 : 0;
    e_vec = 32'((ev << 12) | (el << 11) | (m_own << 10) | (ed << 2) | er);
    a_vec = {19'd0, out_valid, out_last, out_src, out_data, req_ready};
    chk("cycle", a_vec, e_vec);
    if (out_valid && out_ready)
      log_q.push_back('{int'(out_src), int'(out_data), int'(out_last), cyc});
    if (rst) begin
      if (!m_lock) begin
        fnd = 1'b0;
        for (int k = 0; k < NR; k++) begin
          jj = (m_ptr + k) % NR;
          if (!fnd && req_valid[jj]) begin
            fnd    = 1'b1;
            m_lock = 1'b1;
            m_own  = jj;
            m_cnt  = 0;
          end
        end
      end else if (ev == 1 && out_ready) begin
        if (el == 1) begin
          m_lock = 1'b0;
          m_ptr  = (m_own + 1) % NR;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    log_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_beats(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(nm, log_q.size(), n);
  endtask

  task automatic chk_beat(input string nm, input int i, input int src,
                          input int data, input int last);
    if (i >= log_q.size()) begin
      chk(nm, 32'hdead, 32'(i));
    end else begin
      chk(nm, {log_q[i].src[7:0], log_q[i].data[15:0], log_q[i].last[7:0]},
          {src[7:0], data[15:0], last[7:0]});
    end
  endtask

  function automatic word_t w(input int d, input bit l);
    return '{d: d[7:0], l: l};
  endfunction

  int pc;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values.
    #1;
    chk("rst_out", {out_valid, out_last, out_src, out_data, req_ready}, 0);
    do_reset();

    // Single requester, 3-beat packet.
    pc = cyc;
    q0.push_back(w(8'hA0, 0));
    q0.push_back(w(8'hA1, 0));
    q0.push_back(w(8'hA2, 1));
    wait_beats("t1_n", 3, 20);
    chk_beat("t1_b0", 0, 0, 8'hA0, 0);
    chk_beat("t1_b1", 1, 0, 8'hA1, 0);
    chk_beat("t1_b2", 2, 0, 8'hA2, 1);
    if (log_q.size() >= 3) begin
      chk("t1_c0", log_q[0].cyc, pc + 2);
      chk("t1_c2", log_q[2].cyc, pc + 4);
    end

    // Both requesters, single-beat packets, alternate grants.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(w(8'h10 + i, 1));
      q1.push_back(w(8'h20 + i, 1));
    end
    wait_beats("t2_n", 8, 40);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk_beat("t2_b", i, i % 2, (i % 2 == 0 ? 8'h10 : 8'h20) + i / 2, 1);
      if (i > 0) chk("t2_gap", log_q[i].cyc - log_q[i-1].cyc, 2);
    end

    // Backpressure for two cycles in the middle of a packet.
    log_q.delete();
    pc = cyc;
    for (int i = 0; i < 4; i++) q0.push_back(w(8'h30 + i, i == 3));
    tick();
    tick();
    ready_drv = 1'b0;
    @(negedge clk);
    #1;
    chk("t3_stall", {out_valid, out_data, req_ready}, {1'b1, 8'h31, 2'b00});
    tick();
    tick();
    ready_drv = 1'b1;
    wait_beats("t3_n", 4, 20);
    for (int i = 0; i < 4; i++) chk_beat("t3_b", i, 0, 8'h30 + i, i == 3);
    if (log_q.size() >= 4) begin
      chk("t3_c0", log_q[0].cyc, pc + 2);
      chk("t3_c1", log_q[1].cyc, pc + 5);
      chk("t3_c3", log_q[3].cyc, pc + 7);
    end

    // Forced release at MB beats; req0 slips in before the residue.
    log_q.delete();
    for (int i = 0; i < 6; i++) q1.push_back(w(8'hB0 + i, 0));
    q0.push_back(w(8'hC0, 0));
    q0.push_back(w(8'hC1, 1));
    wait_beats("t4_n", 8, 60);
    chk_beat("t4_b0", 0, 1, 8'hB0, 0);
    chk_beat("t4_b3", 3, 1, 8'hB3, 1);
    chk_beat("t4_b4", 4, 0, 8'hC0, 0);
    chk_beat("t4_b5", 5, 0, 8'hC1, 1);
    chk_beat("t4_b6", 6, 1, 8'hB4, 0);
    chk_beat("t4_b7", 7, 1, 8'hB5, 0);

    // Reset during beat 2 of a 3-beat packet.
    do_reset();
    q1.push_back(w(8'hD0, 0));
    q1.push_back(w(8'hD1, 0));
    q1.push_back(w(8'hD2, 1));
    tick();
    tick();
    rst = 1'b0;
    q1.delete();
    log_q.delete();
    @(negedge clk);
    #1;
    chk("t5_zero", {out_valid, out_last, out_src, out_data, req_ready}, 0);
    tick();
    rst = 1'b1;
    q0.push_back(w(8'hE0, 1));
    q1.push_back(w(8'hF0, 1));
    wait_beats("t5_n", 2, 20);
    chk_beat("t5_b0", 0, 0, 8'hE0, 1);
    chk_beat("t5_b1", 1, 1, 8'hF0, 1);

    // Depth-4 FIFO sink with a stalled reader.
    do_reset();
    fifo_mode = 1'b1;
    for (int i = 0; i < 6; i++) q0.push_back(w(8'h40 + i, i == 5));
    repeat (12) tick();
    chk("t6_full_n", log_q.size(), 4);
    chk("t6_full_f", fifo_n, 4);
    chk_beat("t6_b3", 3, 0, 8'h43, 1);
    pop_req = 1'b1;
    repeat (6) tick();
    chk("t6_one_n", log_q.size(), 5);
    chk("t6_one_f", fifo_n, 4);
    for (int i = 0; i < 12; i++) begin
      pop_req = 1'b1;
      tick();
    end
    chk("t6_pop_n", popped.size(), 6);
    for (int i = 0; i < 6 && i < popped.size(); i++)
      chk("t6_pop", popped[i], 8'h40 + i);
    chk_beat("t6_b5", 5, 0, 8'h45, 1);
    chk("t6_empty", fifo_n, 0);
    fifo_mode = 1'b0;

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
